// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one read outstanding and buffers words in a FIFO.
// Optional RISCV_FETCH_BYPASS_EN forwards a response straight to the consumer when the buffer is empty.
module riscv_fetch_unit #(
    parameter int                   BUS_WIDTH  = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    output logic                 o_IMEM_REQ,
    output logic [BUS_WIDTH-1:0] o_IMEM_ADDR,
    input  logic                 i_IMEM_VALID,
    input  logic [BUS_WIDTH-1:0] i_IMEM_DATA,
    output logic [BUS_WIDTH-1:0] o_INSTR,
    output logic [BUS_WIDTH-1:0] o_INSTR_PC,
    output logic                 o_INSTR_VALID,
    input  logic                 i_INSTR_READY,
    input  logic                 i_REDIRECT,
    input  logic [BUS_WIDTH-1:0] i_REDIRECT_PC
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [BUS_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
    logic                 req_q, req_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic                 push_s, pop_s, bypass_s;

    assign pop_s = (count_q != {CW{1'b0}}) && i_INSTR_READY;

`ifdef RISCV_FETCH_BYPASS_EN
    assign bypass_s = (count_q == {CW{1'b0}}) && (state_q == S_BUSY) && i_IMEM_VALID
                      && i_INSTR_READY && !i_REDIRECT;
`else
    assign bypass_s = 1'b0;
`endif

    // State, PC, request and FIFO registers
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            req_q      <= 1'b0;
            addr_q     <= {BUS_WIDTH{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i] <= {BUS_WIDTH{1'b0}};
                pc_mem_q[i]   <= {BUS_WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            if (push_s) begin
                data_mem_q[wr_ptr_q] <= i_IMEM_DATA;
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            end
        end
    end

    // Next-state: redirect wins, then response handling, then the issue decision
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push_s     = 1'b0;
        req_d      = 1'b0;
        addr_d     = addr_q;
        if (i_REDIRECT) begin
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            fetch_pc_d = i_REDIRECT_PC & ~BUS_WIDTH'(3);
            case (state_q)
                S_BUSY:  state_d = i_IMEM_VALID ? S_IDLE : S_DRAIN;
                S_DRAIN: state_d = i_IMEM_VALID ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_BUSY: begin
                    if (i_IMEM_VALID) begin
                        state_d    = S_IDLE;
                        fetch_pc_d = fetch_pc_q + BUS_WIDTH'(4);
                        push_s     = !bypass_s;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_DRAIN: state_d = i_IMEM_VALID ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        end
        // Issue only with a free slot reserved for the returning word
        if ((state_d == S_IDLE) && (count_d < CW'(FIFO_DEPTH))) begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            addr_d  = fetch_pc_d;
        end else begin
            req_d = 1'b0;
        end
    end

    // Output decode: FIFO head, or the live response when bypassing
    always_comb begin
        o_IMEM_REQ  = req_q;
        o_IMEM_ADDR = addr_q;
        if (bypass_s) begin
            o_INSTR       = i_IMEM_DATA;
            o_INSTR_PC    = fetch_pc_q;
            o_INSTR_VALID = 1'b1;
        end else begin
            o_INSTR       = data_mem_q[rd_ptr_q];
            o_INSTR_PC    = pc_mem_q[rd_ptr_q];
            o_INSTR_VALID = (count_q != {CW{1'b0}});
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios plus randomized traffic
// compared against a transaction-level queue model of the fetch stage.
module tb_riscv_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    always #5 clk = ~clk;

    riscv_fetch_unit #(.BUS_WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .i_CLK(clk), .i_RST_N(rst_n),
        .o_IMEM_REQ(imem_req), .o_IMEM_ADDR(imem_addr),
        .i_IMEM_VALID(imem_valid), .i_IMEM_DATA(imem_data),
        .o_INSTR(instr), .o_INSTR_PC(instr_pc), .o_INSTR_VALID(instr_valid),
        .i_INSTR_READY(instr_ready),
        .i_REDIRECT(redirect), .i_REDIRECT_PC(redirect_pc)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: next fetch address, outstanding/stale request, buffered {instr, pc}
    logic [31:0] m_pc;
    bit          m_out, m_stale, m_req_exp;
    logic [31:0] m_addr_exp;
    logic [63:0] m_q[$];

    // Memory model
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_fix = 1;
    bit          lat_rand = 1'b0;
    int          req_seen = 0;
    bit          last_req;

    function automatic logic [31:0] dfn(input logic [31:0] a);
        return 32'h0000_00A0 + ((a - 32'h0000_0100) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
        m_pc = RPC; m_out = 1'b0; m_stale = 1'b0; m_req_exp = 1'b0;
        m_q.delete();
        mem_pend = 1'b0; mem_cnt = 0;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs at negedge, check outputs, then advance the model across the posedge
    task automatic cyc(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          byp;
        bit          exp_v;
        if (imem_valid) mem_pend = 1'b0;
        if (mem_pend && mem_cnt > 0) mem_cnt--;
        imem_valid  = mem_pend && (mem_cnt == 0);
        imem_data   = imem_valid ? dfn(mem_addr) : $urandom;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        byp = 1'b0;
`ifdef RISCV_FETCH_BYPASS_EN
        byp = (m_q.size() == 0) && m_out && !m_stale && imem_valid && rdy && !redir;
`endif
        exp_v = (m_q.size() != 0) || byp;
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_v});
        if (m_q.size() != 0) begin
            chk("instr", instr, m_q[0][63:32]);
            chk("instr_pc", instr_pc, m_q[0][31:0]);
        end else if (byp) begin
            chk("bypass_instr", instr, imem_data);
            chk("bypass_pc", instr_pc, m_pc);
        end
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req_exp});
        if (m_req_exp) chk("imem_addr", imem_addr, m_addr_exp);
        last_req = imem_req;
        if (imem_req) begin
            req_seen++;
            mem_pend = 1'b1;
            mem_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
            mem_addr = imem_addr;
        end
        if (redir) begin
            m_q.delete();
            m_pc = rpc & ~32'h3;
            if (m_out && imem_valid) begin
                m_out = 1'b0; m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else begin
            if (m_q.size() != 0 && rdy) m_q.delete(0);
            if (m_out && imem_valid) begin
                if (!m_stale) begin
                    if (!byp) m_q.push_back({imem_data, m_pc});
                    m_pc = m_pc + 32'd4;
                end
                m_out = 1'b0; m_stale = 1'b0;
            end
        end
        m_req_exp = 1'b0;
        if (!m_out && m_q.size() < DEPTH) begin
            m_out = 1'b1; m_req_exp = 1'b1; m_addr_exp = m_pc;
        end
        @(negedge clk);
    endtask

    initial begin
        bit got;
        @(negedge clk);
        // Reset then steady streaming with 1-cycle memory
        reset_dut();
        lat_fix = 1; lat_rand = 1'b0;
        repeat (14) cyc(1'b1, 1'b0, 32'h0);

        // Back-pressure: buffer fills, requests stop, then drains in order
        reset_dut();
        req_seen = 0;
        repeat (20) cyc(1'b0, 1'b0, 32'h0);
        chk("full_req_pulses", req_seen, 32'd4);
        chk("full_head_pc", instr_pc, 32'h0000_0100);
        repeat (20) cyc(1'b1, 1'b0, 32'h0);

        // Redirect while a slow request is in flight
        reset_dut();
        lat_fix = 3;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            got = last_req;
        end
        chk("t4_req_seen", {31'd0, got}, 32'd1);
        cyc(1'b1, 1'b1, 32'h0000_0200);
        repeat (14) cyc(1'b1, 1'b0, 32'h0);

        // Misaligned redirect with two buffered entries, then pop+redirect together
        reset_dut();
        lat_fix = 1;
        for (int i = 0; i < 20 && m_q.size() < 2; i++) cyc(1'b0, 1'b0, 32'h0);
        chk("t5_two_buffered", m_q.size(), 32'd2);
        cyc(1'b0, 1'b1, 32'h0000_0203);
        cyc(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20 && m_q.size() == 0; i++) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0000_0300);
        repeat (10) cyc(1'b1, 1'b0, 32'h0);

        // Address wrap at the top of the address space
        cyc(1'b1, 1'b1, 32'hFFFF_FFF9);
        repeat (12) cyc(1'b1, 1'b0, 32'h0);

        // Randomized traffic with variable latency, back-pressure, redirects and a mid-run reset
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_dut();
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
